// File: rtl/instr_encoder_if.sv
// instr_encoder_if: field-bundle input and packed-word output bus for instr_encoder.
//
// Signals:
//   start                  pulse: reload address counter to BASE_ADDR, clear err_cnt
//   in_valid / in_ready    input handshake for one decoded field bundle
//   in_opcode .. in_imm    decoded instruction fields (in_imm sign-extended)
//   out_valid / out_ready  output handshake for one packed word
//   out_instr              packed RV32I instruction word
//   out_addr               instruction-memory write address of out_instr
//   out_err                immediate out of range or unsupported opcode
//   err_cnt                saturating count of errored words that have been output
//
// Modports: slave = the encoder, master = the producer/consumer driving it.
`timescale 1ns/1ps
interface instr_encoder_if #(
  parameter int ADDR_W = 32
);
  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic [6:0]        in_funct7;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;
  logic [7:0]        err_cnt;

  modport slave (
    input  start, in_valid, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr, out_err, err_cnt
  );

  modport master (
    output start, in_valid, in_opcode, in_rd, in_rs1, in_rs2,
           in_funct3, in_funct7, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, out_err, err_cnt
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields into a 32-bit instruction word,
// tags it with a sequential instruction-memory address and buffers it in a
// 2-entry queue so bundles can stream at one per cycle.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   instr_encoder_if.slave (field input handshake, packed-word output
//         handshake, start pulse, err_cnt)
//
// Parameters:
//   ADDR_W     width of out_addr
//   BASE_ADDR  address of the first word after reset or start
//
// Build option:
//   ENC_RANGE_CHECK_EN  when defined, immediates that do not fit their format
//                       raise out_err (word still emitted, fields truncated).
//                       When undefined, out_err only flags unsupported opcodes.
`timescale 1ns/1ps
module instr_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input logic            clk,
  input logic            rst,
  instr_encoder_if.slave bus
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_J     = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  logic [31:0]       w_instr;
  logic              w_op_err;
  logic              w_range_err;
  logic              w_enc_err;
  logic              w_push;
  logic              w_pop;
  logic              w_out_valid;
  logic [1:0]        w_count_next;

  logic [31:0]       r_q_instr [2];
  logic [ADDR_W-1:0] r_q_addr  [2];
  logic              r_q_err   [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_count;
  logic              r_in_ready;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_err_cnt;

  // Field packing; unsupported opcodes produce an all-zero word.
  always_comb begin
    w_instr  = '0;
    w_op_err = 1'b0;
    case (bus.in_opcode)
      OP_R:
        w_instr = {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
      OP_I, OP_LOAD, OP_JALR:
        w_instr = {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode};
      OP_S:
        w_instr = {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                   bus.in_imm[4:0], bus.in_opcode};
      OP_B:
        w_instr = {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                   bus.in_imm[4:1], bus.in_imm[11], bus.in_opcode};
      OP_J:
        w_instr = {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12],
                   bus.in_rd, bus.in_opcode};
      OP_LUI, OP_AUIPC:
        w_instr = {bus.in_imm[31:12], bus.in_rd, bus.in_opcode};
      default:
        w_op_err = 1'b1;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // An immediate fits when every bit above the format's top bit is a copy of
  // the sign; branch/jump offsets must also be halfword aligned.
  always_comb begin
    w_range_err = 1'b0;
    case (bus.in_opcode)
      OP_I, OP_LOAD, OP_JALR, OP_S:
        w_range_err = !((&bus.in_imm[31:11]) || !(|bus.in_imm[31:11]));
      OP_B:
        w_range_err = !((&bus.in_imm[31:12]) || !(|bus.in_imm[31:12])) || bus.in_imm[0];
      OP_J:
        w_range_err = !((&bus.in_imm[31:20]) || !(|bus.in_imm[31:20])) || bus.in_imm[0];
      OP_LUI, OP_AUIPC:
        w_range_err = |bus.in_imm[11:0];
      default:
        w_range_err = 1'b0;
    endcase
  end
`else
  assign w_range_err = 1'b0;
`endif

  assign w_enc_err   = w_op_err | w_range_err;
  assign w_out_valid = (r_count != 2'd0);
  assign w_push      = bus.in_valid & r_in_ready;
  assign w_pop       = w_out_valid & bus.out_ready;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  // Queue storage: no reset needed, occupancy is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_instr[r_wr_ptr] <= w_instr;
      r_q_addr[r_wr_ptr]  <= r_addr;
      r_q_err[r_wr_ptr]   <= w_enc_err;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_count    <= 2'd0;
      r_in_ready <= 1'b1;
      r_addr     <= BASE_ADDR;
      r_err_cnt  <= 8'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count    <= w_count_next;
      // Registered from the next occupancy so it never depends on out_ready
      // combinationally.
      r_in_ready <= (w_count_next != 2'd2);
      // A push alongside start still consumed the old address above.
      if (bus.start)   r_addr <= BASE_ADDR;
      else if (w_push) r_addr <= r_addr + ADDR_W'(4);
      // start wins over a simultaneous errored pop.
      if (bus.start)
        r_err_cnt <= 8'd0;
      else if (w_pop && r_q_err[r_rd_ptr] && (r_err_cnt != 8'hFF))
        r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_instr = w_out_valid ? r_q_instr[r_rd_ptr] : 32'd0;
  assign bus.out_addr  = w_out_valid ? r_q_addr[r_rd_ptr]  : r_addr;
  assign bus.out_err   = w_out_valid ? r_q_err[r_rd_ptr]   : 1'b0;
  assign bus.err_cnt   = r_err_cnt;
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the immediate decoder: packs decoded instruction fields (opcode, registers, funct fields, 32-bit immediate) into a 32-bit RV32I instruction word.
- Used by the boot/test loader path that writes instruction memory. Each packed word carries a sequential write address.
- Accepts fields over a valid/ready handshake and range-checks the immediate per format.
- Buffers results in a 2-entry output queue so it can stream at full throughput.

Parameters:
- ADDR_W, 32, width of out_addr.
- BASE_ADDR, 32'h0000_0000, address given to the first word after reset or start.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  pulse; reloads the address counter to BASE_ADDR and clears err_cnt
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept a bundle
- in_opcode  input  7  instr[6:0]
- in_rd  input  5  destination register
- in_rs1  input  5  source register 1
- in_rs2  input  5  source register 2
- in_funct3  input  3  funct3
- in_funct7  input  7  funct7 (R-type only)
- in_imm  input  32  immediate, byte value, sign-extended
- out_valid  output  1  packed word valid
- out_ready  input  1  consumer accepts the word
- out_instr  output  32  packed instruction
- out_addr  output  ADDR_W  write address of out_instr
- out_err  output  1  immediate out of range, or unsupported opcode
- err_cnt  output  8  saturating count of errored words that have been output

Behaviour:
- Reset values: in_ready=1, out_valid=0, out_instr=0, out_err=0, out_addr=BASE_ADDR, err_cnt=0, queue empty.
- Input handshake: a bundle is accepted on a cycle with in_valid && in_ready. in_ready = (queue count < 2), registered. in_ready does not depend combinationally on out_ready.
- Latency: a bundle accepted in cycle N is packed combinationally and written to the queue. It is visible at the queue head in cycle N+1 if the queue was empty.
- Output handshake: a word is consumed on a cycle with out_valid && out_ready. While out_valid && !out_ready, out_instr, out_addr and out_err must hold stable.
- Push and pop in the same cycle: count is unchanged and order is preserved. At count 2 no push can occur.
- Address: stored with each entry when it is pushed. The counter increments by 4 on every push and wraps modulo 2^ADDR_W.
- start:
  - The counter loads BASE_ADDR.
  - A push in the same cycle takes the old address; the counter then still loads BASE_ADDR.
  - Queued words keep their addresses.
  - err_cnt clears; a simultaneous errored pop is not counted.
- Packing by opcode:
  - R 0110011: funct7|rs2|rs1|funct3|rd|op.
  - I 0010011, LOAD 0000011, JALR 1100111: imm[11:0]|rs1|funct3|rd|op.
  - S 0100011: imm[11:5]|rs2|rs1|funct3|imm[4:0]|op.
  - SB 1100011: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op.
  - UJ 1101111: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
  - U 0110111, AUIPC 0010111: imm[31:12]|rd|op.
  - Any other opcode: out_instr=0, out_err=1. This error is raised regardless of the macro.
- Range rules, where err means the word is still emitted and its fields are truncated:
  - I/LOAD/JALR/S: in_imm[31:11] must be all equal to each other.
  - SB: in_imm[31:12] must be all equal, and imm[0] must be 0.
  - UJ: in_imm[31:20] must be all equal, and imm[0] must be 0.
  - U/AUIPC: imm[11:0] must be 0.
  - R: in_imm is ignored; no range error.
- err_cnt increments when an errored word is popped, and saturates at 255.
- Reset mid-operation: queued words are discarded and no output is produced until new input arrives.

Optional Feature:
- Macro: ENC_RANGE_CHECK_EN.
- Defined: range rules apply and out_err/err_cnt report them as above.
- Undefined: range checks are removed. Fields are silently truncated, and out_err flags only unsupported opcodes.

Test Plan:
- ADDI: opcode 0010011, rd=1, rs1=0, f3=0, imm=5 after reset -> cycle+1: out_instr=0x00500093, out_addr=0x0, out_err=0.
- SW then JAL, back-to-back, out_ready=1:
  - SW: opcode 0100011, rs1=1, rs2=2, f3=2, imm=-4 -> 0xFE20AE23 @0x0.
  - JAL: opcode 1101111, rd=1, imm=8 -> 0x008000EF @0x4.
  - One word per cycle.
- LUI: opcode 0110111, rd=5, imm=0x12345000 -> 0x123452B7.
- Backpressure: hold out_ready=0 and offer 3 bundles.
  - in_ready falls after 2 accepts.
  - Outputs stay stable.
  - Release out_ready -> 3 words in order @0x0, 0x4, 0x8 with no loss.
- ADDI with imm=2048, macro defined -> out_instr=0x80000093, out_err=1, and err_cnt=1 after the pop. Macro undefined -> out_err=0.
- start asserted on the push of the 3rd word -> that word @0x8, next push @0x0, err_cnt=0. Opcode 1111111 -> out_instr=0, out_err=1.
